// File: rtl/id_seg.sv
// Instruction-decode stage of a 5-stage MIPS-like pipeline.
// Holds the 32x32 register file with write-through bypass from WB, decodes the
// instruction coming from fetch, detects load-use hazards against the load in EX
// and loads the ID/EX pipeline register (or a bubble) on every rising edge.
module id_seg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] PCi,
  input  logic [31:0] NPCi,
  input  logic        flush,
  input  logic        exMemRead,
  input  logic [4:0]  exRt,
  input  logic        wbEn,
  input  logic [4:0]  wbAddr,
  input  logic [31:0] wbData,
  output logic        stall,
  output logic [31:0] IRo,
  output logic [31:0] PCo,
  output logic [31:0] NPCo,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] Imm,
  output logic [4:0]  dst,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        isBranch,
  output logic        isJump,
  output logic        illegal,
  output logic [31:0] jTarget
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] regs_r [32];

  logic [5:0]  op_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [31:0] rs_val_s, rt_val_s;
  logic [31:0] imm_s;
  logic [4:0]  dst_s;
  logic        wr_s, mem_read_s, mem_write_s, branch_s, jump_s, illegal_s, jal_s;
  logic        uses_rt_s, hazard_s, bubble_s;

  assign op_s = IRi[31:26];
  assign rs_s = IRi[25:21];
  assign rt_s = IRi[20:16];
  assign rd_s = IRi[15:11];

  // Register read with same-cycle bypass of the WB write; $0 always reads zero.
  always_comb begin
    rs_val_s = 32'd0;
    rt_val_s = 32'd0;
    if (wbEn && (wbAddr == rs_s) && (rs_s != 5'd0)) begin
      rs_val_s = wbData;
    end else if (rs_s != 5'd0) begin
      rs_val_s = regs_r[rs_s];
    end else begin
      rs_val_s = 32'd0;
    end
    if (wbEn && (wbAddr == rt_s) && (rt_s != 5'd0)) begin
      rt_val_s = wbData;
    end else if (rt_s != 5'd0) begin
      rt_val_s = regs_r[rt_s];
    end else begin
      rt_val_s = 32'd0;
    end
  end

  // Opcode decode into control, destination and extended immediate.
  always_comb begin
    imm_s       = 32'd0;
    dst_s       = 5'd0;
    wr_s        = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    jump_s      = 1'b0;
    jal_s       = 1'b0;
    illegal_s   = 1'b0;
    uses_rt_s   = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        dst_s     = rd_s;
        wr_s      = 1'b1;
        uses_rt_s = 1'b1;
      end
      OP_ADDI: begin
        imm_s = {{16{IRi[15]}}, IRi[15:0]};
        dst_s = rt_s;
        wr_s  = 1'b1;
      end
      OP_ORI: begin
        imm_s = {16'd0, IRi[15:0]};
        dst_s = rt_s;
        wr_s  = 1'b1;
      end
      OP_LW: begin
        imm_s      = {{16{IRi[15]}}, IRi[15:0]};
        dst_s      = rt_s;
        wr_s       = 1'b1;
        mem_read_s = 1'b1;
      end
      OP_SW: begin
        imm_s       = {{16{IRi[15]}}, IRi[15:0]};
        mem_write_s = 1'b1;
        uses_rt_s   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        imm_s     = {{16{IRi[15]}}, IRi[15:0]};
        branch_s  = 1'b1;
        uses_rt_s = 1'b1;
      end
      OP_J: begin
        jump_s = 1'b1;
      end
      OP_JAL: begin
        jump_s = 1'b1;
        jal_s  = 1'b1;
        dst_s  = 5'd31;
        wr_s   = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // A load in EX feeding a source of this instruction forces a one-cycle bubble.
  assign hazard_s = exMemRead && (exRt != 5'd0) &&
                    ((exRt == rs_s) || ((exRt == rt_s) && uses_rt_s));
  assign stall    = hazard_s && !flush && !rst;
  assign bubble_s = hazard_s || flush;

  // Register file: synchronous clear on reset, WB write otherwise ($0 never written).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wbEn && (wbAddr != 5'd0)) begin
      regs_r[wbAddr] <= wbData;
    end else begin
      regs_r[0] <= 32'd0;
    end
  end

  // ID/EX register: reset and bubbles load all-zero, otherwise the decoded instruction.
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      IRo      <= 32'd0;
      PCo      <= 32'd0;
      NPCo     <= 32'd0;
      A        <= 32'd0;
      B        <= 32'd0;
      Imm      <= 32'd0;
      dst      <= 5'd0;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      isBranch <= 1'b0;
      isJump   <= 1'b0;
      illegal  <= 1'b0;
      jTarget  <= 32'd0;
    end else begin
      IRo      <= IRi;
      PCo      <= PCi;
      NPCo     <= NPCi;
      A        <= rs_val_s;
      B        <= jal_s ? NPCi : rt_val_s;
      Imm      <= imm_s;
      dst      <= dst_s;
      regWrite <= wr_s && (dst_s != 5'd0);
      memRead  <= mem_read_s;
      memWrite <= mem_write_s;
      isBranch <= branch_s;
      isJump   <= jump_s;
      illegal  <= illegal_s;
      jTarget  <= {NPCi[31:28], IRi[25:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_id_seg.sv
// Self-checking bench for id_seg: directed scenarios followed by randomized
// traffic, all compared against an instruction-level reference model.
module tb_id_seg;

  logic        clk = 1'b0;
  logic        rst, flush, exMemRead, wbEn;
  logic [4:0]  exRt, wbAddr;
  logic [31:0] IRi, PCi, NPCi, wbData;
  logic        stall;
  logic [31:0] IRo, PCo, NPCo, A, B, Imm, jTarget;
  logic [4:0]  dst;
  logic        regWrite, memRead, memWrite, isBranch, isJump, illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic stall_seen;
  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  id_seg dut (
    .clk(clk), .rst(rst), .IRi(IRi), .PCi(PCi), .NPCi(NPCi), .flush(flush),
    .exMemRead(exMemRead), .exRt(exRt), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .stall(stall), .IRo(IRo), .PCo(PCo), .NPCo(NPCo), .A(A), .B(B), .Imm(Imm),
    .dst(dst), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .isBranch(isBranch), .isJump(isJump), .illegal(illegal), .jTarget(jTarget)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register value as seen by decode, including a same-cycle WB write.
  function automatic logic [31:0] read_reg(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  // One pipeline cycle: drive inputs, check stall, predict ID/EX contents, check after edge.
  task automatic step(input logic r, input logic fl, input logic [31:0] ir,
                      input logic [31:0] pc, input logic [31:0] npc,
                      input logic emr, input logic [4:0] ert,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic hz, known, uses_rt, bub;
    logic [31:0] e_ir, e_pc, e_npc, e_a, e_b, e_imm, e_jt;
    logic [4:0] e_dst;
    logic e_rw, e_mr, e_mw, e_br, e_jp, e_il;
    @(negedge clk);
    rst = r; flush = fl; IRi = ir; PCi = pc; NPCi = npc;
    exMemRead = emr; exRt = ert; wbEn = we; wbAddr = wa; wbData = wd;
    op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    known   = op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    uses_rt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    hz  = emr && (ert != 5'd0) && ((ert == rs) || ((ert == rt) && uses_rt));
    bub = r || fl || hz;
    #1;
    stall_seen = stall;
    check_eq("stall", 32'(stall), 32'(!r && !fl && hz));
    e_ir = 32'd0; e_pc = 32'd0; e_npc = 32'd0; e_a = 32'd0; e_b = 32'd0;
    e_imm = 32'd0; e_jt = 32'd0; e_dst = 5'd0;
    e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_br = 1'b0; e_jp = 1'b0; e_il = 1'b0;
    if (!bub) begin
      e_ir = ir; e_pc = pc; e_npc = npc;
      e_a = read_reg(rs, we, wa, wd);
      e_b = (op == 6'h03) ? npc : read_reg(rt, we, wa, wd);
      if (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h05}) e_imm = {{16{ir[15]}}, ir[15:0]};
      else if (op == 6'h0D) e_imm = {16'd0, ir[15:0]};
      if (op == 6'h00) e_dst = rd;
      else if (op inside {6'h08, 6'h0D, 6'h23}) e_dst = rt;
      else if (op == 6'h03) e_dst = 5'd31;
      e_rw = (op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h03}) && (e_dst != 5'd0);
      e_mr = (op == 6'h23);
      e_mw = (op == 6'h2B);
      e_br = (op inside {6'h04, 6'h05});
      e_jp = (op inside {6'h02, 6'h03});
      e_il = !known;
      e_jt = {npc[31:28], ir[25:0], 2'b00};
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      mregs[wa] = wd;
    end
    #1;
    check_eq("IRo", IRo, e_ir);
    check_eq("PCo", PCo, e_pc);
    check_eq("NPCo", NPCo, e_npc);
    check_eq("A", A, e_a);
    check_eq("B", B, e_b);
    check_eq("Imm", Imm, e_imm);
    check_eq("dst", 32'(dst), 32'(e_dst));
    check_eq("regWrite", 32'(regWrite), 32'(e_rw));
    check_eq("memRead", 32'(memRead), 32'(e_mr));
    check_eq("memWrite", 32'(memWrite), 32'(e_mw));
    check_eq("isBranch", 32'(isBranch), 32'(e_br));
    check_eq("isJump", 32'(isJump), 32'(e_jp));
    check_eq("illegal", 32'(illegal), 32'(e_il));
    check_eq("jTarget", jTarget, e_jt);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ir;
    rst = 1'b1; flush = 1'b0; IRi = 32'd0; PCi = 32'd0; NPCi = 32'd0;
    exMemRead = 1'b0; exRt = 5'd0; wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

    // Reset with hazard, flush and WB write all present: reset must win.
    step(1'b1, 1'b1, 32'h00873020, 32'h100, 32'h104, 1'b1, 5'd4, 1'b1, 5'd4, 32'hDEAD);
    check_eq("rst_stall", 32'(stall_seen), 32'd0);
    check_eq("rst_iro", IRo, 32'd0);

    // add $3,$5,$0 with a WB write of $5 in the same cycle.
    step(1'b0, 1'b0, 32'h00A01820, 32'h00400000, 32'h00400004, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234);
    check_eq("bypass_a", A, 32'h00001234);
    check_eq("bypass_dst", 32'(dst), 32'd3);
    check_eq("bypass_rw", 32'(regWrite), 32'd1);

    // Immediate extension.
    step(1'b0, 1'b0, 32'h2022FFFC, 32'h00400004, 32'h00400008, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("addi_imm", Imm, 32'hFFFFFFFC);
    step(1'b0, 1'b0, 32'h3422FFFC, 32'h00400008, 32'h0040000C, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("ori_imm", Imm, 32'h0000FFFC);

    // Load-use hazard on rs, then the load leaves EX.
    step(1'b0, 1'b0, 32'h00873020, 32'h0040000C, 32'h00400010, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    check_eq("hz_stall", 32'(stall_seen), 32'd1);
    check_eq("hz_bubble", IRo, 32'd0);
    step(1'b0, 1'b0, 32'h00873020, 32'h0040000C, 32'h00400010, 1'b0, 5'd4, 1'b0, 5'd0, 32'd0);
    check_eq("hz_release_stall", 32'(stall_seen), 32'd0);
    check_eq("hz_release_iro", IRo, 32'h00873020);

    // Flush beats the hazard.
    step(1'b0, 1'b1, 32'h00873020, 32'h0040000C, 32'h00400010, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    check_eq("flush_stall", 32'(stall_seen), 32'd0);
    check_eq("flush_rw", 32'(regWrite), 32'd0);

    // jal.
    step(1'b0, 1'b0, 32'h0C100000, 32'h00400004, 32'h00400008, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("jal_dst", 32'(dst), 32'd31);
    check_eq("jal_b", B, 32'h00400008);
    check_eq("jal_jt", jTarget, 32'h00400000);
    check_eq("jal_jump", 32'(isJump), 32'd1);

    // Writes to $0 are dropped, then read $0.
    step(1'b0, 1'b0, 32'h00001820, 32'h0, 32'h4, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000FFFF);
    check_eq("r0_bypass", A, 32'd0);
    step(1'b0, 1'b0, 32'h00001820, 32'h0, 32'h4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("r0_read", A, 32'd0);

    // Unknown opcode, then a plain NOP.
    step(1'b0, 1'b0, 32'hFC221234, 32'h0, 32'h4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("ill_flag", 32'(illegal), 32'd1);
    check_eq("ill_rw", 32'(regWrite), 32'd0);
    step(1'b0, 1'b0, 32'h00000000, 32'h4, 32'h8, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("nop_ill", 32'(illegal), 32'd0);

    // Randomized traffic on a small register window to hit bypass and hazards often.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 11))
        0:  op = 6'h00;  1: op = 6'h08;  2: op = 6'h0D;  3: op = 6'h23;
        4:  op = 6'h2B;  5: op = 6'h04;  6: op = 6'h05;  7: op = 6'h02;
        8:  op = 6'h03;  9: op = 6'h00;
        10: begin
          op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03})
            op = 6'($urandom_range(0, 63));
        end
        default: op = 6'h00;
      endcase
      ir = $urandom;
      ir[31:26] = op;
      ir[25:21] = 5'($urandom_range(0, 7));
      ir[20:16] = 5'($urandom_range(0, 7));
      ir[15:11] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ir = 32'd0;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), ir,
           $urandom, $urandom, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
